pause_fade: RTL and testbench

Second-generation pause controller for MiSTer cores, between the core's CPU/video logic and the arcade video output. It merges N user pause buttons, an external pause request and the OSD-open condition into one CPU pause signal. Pause entry and exit can optionally be aligned to the vertical blanking edge. After a configurable idle time it fades the picture in discrete brightness steps, and it outputs registered RGB with matching delayed sync/blank signals.

---
 rtl/pause_fade.sv | 182 ++++++++++++++++++
 tb/tb_pause_fade.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pause_fade.sv
// pause_fade: pause controller with optional vblank-aligned entry/exit and a
// timed brightness fade while paused.
//
// Ports:
//   clk_sys                  core system clock
//   reset                    synchronous active-high reset
//   user_button[NBTN-1:0]    pause buttons, any rising edge toggles user_paused
//   pause_request            pause held by other logic
//   options[2:0]             [0] pause on OSD, [1] dim enable, [2] vblank-aligned
//   OSD_STATUS               OSD open
//   hs, vs, hbl, vbl         video sync/blank in (vbl also used for alignment)
//   r, g, b                  colour in
//   pause_cpu                CPU halt
//   user_paused              user toggle state
//   dim_level[2:0]           current right-shift applied to colour
//   rgb_out                  registered {r,g,b} after dimming
//   hs_out..vbl_out          sync/blank delayed by one clock to match rgb_out
module pause_fade #(
    parameter int unsigned RW      = 8,
    parameter int unsigned GW      = 8,
    parameter int unsigned BW      = 8,
    parameter int unsigned CLKSPD  = 12,
    parameter int unsigned NBTN    = 2,
    parameter int unsigned DIM_MS  = 10000,
    parameter int unsigned FADE_MS = 250,
    parameter int unsigned MAX_DIM = 3
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NBTN-1:0]       user_button,
    input  logic                  pause_request,
    input  logic [2:0]            options,
    input  logic                  OSD_STATUS,
    input  logic                  hs,
    input  logic                  vs,
    input  logic                  hbl,
    input  logic                  vbl,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic                  pause_cpu,
    output logic                  user_paused,
    output logic [2:0]            dim_level,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic                  hbl_out,
    output logic                  vbl_out
);

    localparam int unsigned PreW  = $clog2(CLKSPD * 1000);
    localparam int unsigned DimW  = $clog2(DIM_MS + 2);
    localparam int unsigned StepW = $clog2(FADE_MS + 2);

    localparam logic [PreW-1:0]  PreLast  = PreW'(CLKSPD * 1000 - 1);
    localparam logic [DimW-1:0]  DimSat   = DimW'(DIM_MS);
    localparam logic [StepW-1:0] StepLast = StepW'(FADE_MS - 1);
    localparam logic [2:0]       DimMax   = 3'(MAX_DIM);

    typedef enum logic [1:0] {
        StRun,
        StPendPause,
        StPaused,
        StPendRun
    } state_e;

    state_e            state_q, state_d;
    logic [NBTN-1:0]   btn_last_q;
    logic              user_paused_q;
    logic              vbl_last_q;
    logic [PreW-1:0]   presc_q, presc_d;
    logic [DimW-1:0]   dim_cnt_q, dim_cnt_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [2:0]        level_q, level_d;
    logic [RW+GW+BW-1:0] rgb_q;
    logic              hs_q, vs_q, hbl_q, vbl_q;

    logic btn_rise;
    logic want;
    logic vbl_rise;
    logic dim_active;
    logic ms_tick;

    // Simultaneous edges on several buttons collapse into a single toggle.
    assign btn_rise   = |(user_button & ~btn_last_q);
    assign want       = pause_request | user_paused_q | (OSD_STATUS & options[0]);
    assign vbl_rise   = vbl & ~vbl_last_q;
    assign pause_cpu  = (state_q == StPaused) || (state_q == StPendRun);
    assign dim_active = pause_cpu & options[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (want) state_d = options[2] ? StPendPause : StPaused;
            end
            StPendPause: begin
                if (!want)                        state_d = StRun;
                else if (!options[2] || vbl_rise) state_d = StPaused;
            end
            StPaused: begin
                if (!want) state_d = options[2] ? StPendRun : StRun;
            end
            StPendRun: begin
                if (want)                         state_d = StPaused;
                else if (!options[2] || vbl_rise) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Dim engine: ms prescaler -> idle counter (saturates) -> step counter.
    // The step counter only starts once the idle counter has saturated, so the
    // first dim step lands FADE_MS after the DIM_MS idle period.
    always_comb begin
        presc_d   = presc_q;
        dim_cnt_d = dim_cnt_q;
        step_d    = step_q;
        level_d   = level_q;
        ms_tick   = 1'b0;
        if (!dim_active) begin
            presc_d   = '0;
            dim_cnt_d = '0;
            step_d    = '0;
            level_d   = '0;
        end else begin
            ms_tick = (presc_q == PreLast);
            presc_d = ms_tick ? '0 : presc_q + 1'b1;
            if (ms_tick) begin
                if (dim_cnt_q != DimSat) begin
                    dim_cnt_d = dim_cnt_q + 1'b1;
                end else if (step_q == StepLast) begin
                    step_d = '0;
                    if (level_q != DimMax) level_d = level_q + 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= StRun;
            btn_last_q    <= '0;
            user_paused_q <= 1'b0;
            vbl_last_q    <= 1'b0;
            presc_q       <= '0;
            dim_cnt_q     <= '0;
            step_q        <= '0;
            level_q       <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hbl_q         <= 1'b0;
            vbl_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_last_q    <= user_button;
            user_paused_q <= user_paused_q ^ btn_rise;
            vbl_last_q    <= vbl;
            presc_q       <= presc_d;
            dim_cnt_q     <= dim_cnt_d;
            step_q        <= step_d;
            level_q       <= level_d;
            rgb_q         <= {r >> level_q, g >> level_q, b >> level_q};
            hs_q          <= hs;
            vs_q          <= vs;
            hbl_q         <= hbl;
            vbl_q         <= vbl;
        end
    end

    assign user_paused = user_paused_q;
    assign dim_level   = level_q;
    assign rgb_out     = rgb_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign hbl_out     = hbl_q;
    assign vbl_out     = vbl_q;

endmodule

// File: tb/tb_pause_fade.sv
// Directed bench for pause_fade with a 1 MHz clock so 1 ms = 1000 clocks.
module tb_pause_fade;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  user_button = '0;
    logic        pause_request = 1'b0;
    logic [2:0]  options = '0;
    logic        OSD_STATUS = 1'b0;
    logic        hs = 1'b0, vs = 1'b0, hbl = 1'b0, vbl = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        pause_cpu, user_paused;
    logic [2:0]  dim_level;
    logic [23:0] rgb_out;
    logic        hs_out, vs_out, hbl_out, vbl_out;

    int n_cmp = 0;
    int n_err = 0;

    pause_fade #(
        .RW(8), .GW(8), .BW(8), .CLKSPD(1), .NBTN(2),
        .DIM_MS(2), .FADE_MS(1), .MAX_DIM(2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .user_button  (user_button),
        .pause_request(pause_request),
        .options      (options),
        .OSD_STATUS   (OSD_STATUS),
        .hs           (hs),
        .vs           (vs),
        .hbl          (hbl),
        .vbl          (vbl),
        .r            (r),
        .g            (g),
        .b            (b),
        .pause_cpu    (pause_cpu),
        .user_paused  (user_paused),
        .dim_level    (dim_level),
        .rgb_out      (rgb_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .hbl_out      (hbl_out),
        .vbl_out      (vbl_out)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges; outputs are read 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hs = 1'b1; vs = 1'b1; hbl = 1'b1;
        r = 8'hFF; g = 8'hFF; b = 8'hFF;
        step(2);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL reset_pause got %b want 0", pause_cpu); end
        n_cmp++; if (user_paused !== 1'b0) begin n_err++; $display("FAIL reset_user got %b want 0", user_paused); end
        n_cmp++; if (dim_level !== 3'd0) begin n_err++; $display("FAIL reset_dim got %0d want 0", dim_level); end
        n_cmp++; if (rgb_out !== 24'h0) begin n_err++; $display("FAIL reset_rgb got %h want 000000", rgb_out); end
        n_cmp++; if ({hs_out, vs_out, hbl_out, vbl_out} !== 4'b0) begin
            n_err++; $display("FAIL reset_sync got %b want 0000", {hs_out, vs_out, hbl_out, vbl_out});
        end
        reset = 1'b0; hs = 1'b0; vs = 1'b0; hbl = 1'b0;
        r = 8'h12; g = 8'h34; b = 8'h56;
        step(1);
        n_cmp++; if (rgb_out !== 24'h123456) begin n_err++; $display("FAIL first_rgb got %h want 123456", rgb_out); end
    endtask

    task automatic test_button();
        options = 3'b000;
        user_button = 2'b10;
        step(1);
        user_button = 2'b00;
        n_cmp++; if ({user_paused, pause_cpu} !== 2'b10) begin
            n_err++; $display("FAIL btn1_edge got %b want 10", {user_paused, pause_cpu});
        end
        step(1);
        n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL btn1_pause got %b want 1", pause_cpu); end
        user_button = 2'b01;
        step(1);
        user_button = 2'b00;
        n_cmp++; if ({user_paused, pause_cpu} !== 2'b01) begin
            n_err++; $display("FAIL btn0_edge got %b want 01", {user_paused, pause_cpu});
        end
        step(1);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL btn0_release got %b want 0", pause_cpu); end
        user_button = 2'b11;
        step(1);
        user_button = 2'b00;
        step(1);
        n_cmp++; if ({user_paused, pause_cpu} !== 2'b11) begin
            n_err++; $display("FAIL btn_both got %b want 11", {user_paused, pause_cpu});
        end
        user_button = 2'b01;
        step(1);
        user_button = 2'b00;
        step(2);
        n_cmp++; if ({user_paused, pause_cpu} !== 2'b00) begin
            n_err++; $display("FAIL btn_clear got %b want 00", {user_paused, pause_cpu});
        end
    endtask

    task automatic test_aligned();
        options = 3'b100; vbl = 1'b0;
        pause_request = 1'b1;
        step(4);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL al_pend got %b want 0", pause_cpu); end
        vbl = 1'b1;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL al_enter got %b want 1", pause_cpu); end
        pause_request = 1'b0;
        step(2);
        n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL al_pend_run got %b want 1", pause_cpu); end
        vbl = 1'b0;
        step(1);
        vbl = 1'b1;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL al_exit got %b want 0", pause_cpu); end
        vbl = 1'b0;
        step(1);
        pause_request = 1'b1;
        step(1);
        pause_request = 1'b0;
        step(1);
        vbl = 1'b1;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL al_drop got %b want 0", pause_cpu); end
        pause_request = 1'b1;
        step(4);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL al_vbl_high got %b want 0", pause_cpu); end
        pause_request = 1'b0;
        vbl = 1'b0;
        step(1);
        options = 3'b000;
        step(1);
    endtask

    task automatic test_osd();
        options = 3'b001; OSD_STATUS = 1'b1;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL osd_on got %b want 1", pause_cpu); end
        OSD_STATUS = 1'b0;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL osd_off got %b want 0", pause_cpu); end
        options = 3'b000; OSD_STATUS = 1'b1;
        step(2);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL osd_masked got %b want 0", pause_cpu); end
        OSD_STATUS = 1'b0;
    endtask

    task automatic test_fade();
        options = 3'b010; r = 8'hF0; g = 8'h0F; b = 8'hAA;
        pause_request = 1'b1;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL fade_pause got %b want 1", pause_cpu); end
        step(2999);
        n_cmp++; if (dim_level !== 3'd0) begin n_err++; $display("FAIL fade_pre1 got %0d want 0", dim_level); end
        step(1);
        n_cmp++; if (dim_level !== 3'd1) begin n_err++; $display("FAIL fade_lvl1 got %0d want 1", dim_level); end
        n_cmp++; if (rgb_out[23:16] !== 8'hF0) begin n_err++; $display("FAIL fade_lag got %h want f0", rgb_out[23:16]); end
        step(1);
        n_cmp++; if (rgb_out !== 24'h780755) begin n_err++; $display("FAIL fade_rgb1 got %h want 780755", rgb_out); end
        step(998);
        n_cmp++; if (dim_level !== 3'd1) begin n_err++; $display("FAIL fade_pre2 got %0d want 1", dim_level); end
        step(1);
        n_cmp++; if (dim_level !== 3'd2) begin n_err++; $display("FAIL fade_lvl2 got %0d want 2", dim_level); end
        step(1);
        n_cmp++; if (rgb_out !== 24'h3C032A) begin n_err++; $display("FAIL fade_rgb2 got %h want 3c032a", rgb_out); end
        step(2000);
        n_cmp++; if (dim_level !== 3'd2) begin n_err++; $display("FAIL fade_sat got %0d want 2", dim_level); end
        pause_request = 1'b0;
        step(1);
        n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL fade_unpause got %b want 0", pause_cpu); end
        step(1);
        n_cmp++; if (dim_level !== 3'd0) begin n_err++; $display("FAIL fade_clear got %0d want 0", dim_level); end
        step(1);
        n_cmp++; if (rgb_out !== 24'hF00FAA) begin n_err++; $display("FAIL fade_restore got %h want f00faa", rgb_out); end
    endtask

    task automatic test_reset_mid_pause();
        options = 3'b010;
        user_button = 2'b01;
        step(1);
        user_button = 2'b00;
        step(1);
        step(4001);
        n_cmp++; if ({user_paused, pause_cpu, dim_level} !== 5'b11010) begin
            n_err++; $display("FAIL rmp_pre got %b want 11010", {user_paused, pause_cpu, dim_level});
        end
        reset = 1'b1; user_button = 2'b10; vbl = 1'b1; hs = 1'b1;
        step(1);
        n_cmp++; if ({user_paused, pause_cpu, dim_level} !== 5'b0) begin
            n_err++; $display("FAIL rmp_ctl got %b want 00000", {user_paused, pause_cpu, dim_level});
        end
        n_cmp++; if ({rgb_out, hs_out, vbl_out} !== 26'h0) begin
            n_err++; $display("FAIL rmp_video got %h want 0", {rgb_out, hs_out, vbl_out});
        end
        user_button = 2'b00; vbl = 1'b0; hs = 1'b0;
        reset = 1'b0;
        step(2);
        n_cmp++; if ({user_paused, pause_cpu, dim_level} !== 5'b0) begin
            n_err++; $display("FAIL rmp_after got %b want 00000", {user_paused, pause_cpu, dim_level});
        end
        n_cmp++; if (rgb_out !== 24'hF00FAA) begin n_err++; $display("FAIL rmp_rgb got %h want f00faa", rgb_out); end
        options = 3'b000;
    endtask

    task automatic test_video();
        logic [23:0] exp_rgb;
        logic [3:0]  exp_sync;
        for (int i = 0; i < 16; i++) begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            {hs, vs, hbl, vbl} = 4'($urandom);
            exp_rgb  = {r, g, b};
            exp_sync = {hs, vs, hbl, vbl};
            step(1);
            n_cmp++; if (rgb_out !== exp_rgb) begin
                n_err++; $display("FAIL video_rgb[%0d] got %h want %h", i, rgb_out, exp_rgb);
            end
            n_cmp++; if ({hs_out, vs_out, hbl_out, vbl_out} !== exp_sync) begin
                n_err++; $display("FAIL video_sync[%0d] got %b want %b", i,
                                  {hs_out, vs_out, hbl_out, vbl_out}, exp_sync);
            end
        end
    endtask

    initial begin
        test_reset();
        test_button();
        test_aligned();
        test_osd();
        test_fade();
        test_reset_mid_pause();
        test_video();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
